// File: rtl/dmem_dma_copier.sv
// dmem_dma_copier: block copier that borrows the processor's data-memory port.
// Reads one word (READ), writes it back out (WRITE), repeats for len words,
// then pulses done. Port access is gated by a request/grant pair.
// Optional running checksum of copied words: define DMA_CHECKSUM_EN.
//
// state | meaning
// IDLE  | waiting for start, bus released
// READ  | requesting port, sampling m_rd at src_ptr when granted
// WRITE | requesting port, writing data_reg to dst_ptr when granted
// DONE  | one-cycle completion pulse, bus released
module dmem_dma_copier #(
  parameter int LEN_W    = 8,
  parameter int ADDR_INC = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      src,
  input  logic [31:0]      dst,
  input  logic [LEN_W-1:0] len,
  output logic             bus_req,
  input  logic             bus_gnt,
  output logic             m_we,
  output logic [31:0]      m_a,
  output logic [31:0]      m_wd,
  input  logic [31:0]      m_rd,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [31:0]      checksum
);

  localparam logic [31:0] INC = 32'(ADDR_INC);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      src_ptr_q, src_ptr_d;
  logic [31:0]      dst_ptr_q, dst_ptr_d;
  logic [LEN_W-1:0] count_q, count_d;
  logic [31:0]      data_q, data_d;
  logic             err_q, err_d;
  logic             aligned;

  assign aligned = (src[1:0] == 2'b00) && (dst[1:0] == 2'b00);

  // State and datapath registers; reset abandons any transfer in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      src_ptr_q <= '0;
      dst_ptr_q <= '0;
      count_q   <= '0;
      data_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_ptr_q <= src_ptr_d;
      dst_ptr_q <= dst_ptr_d;
      count_q   <= count_d;
      data_q    <= data_d;
      err_q     <= err_d;
    end
  end

  // Next-state, datapath updates and bus outputs (bus outputs are zero unless requesting).
  always_comb begin
    state_d   = state_q;
    src_ptr_d = src_ptr_q;
    dst_ptr_d = dst_ptr_q;
    count_d   = count_q;
    data_d    = data_q;
    err_d     = err_q;
    bus_req   = 1'b0;
    m_we      = 1'b0;
    m_a       = '0;
    m_wd      = '0;
    done      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (aligned) begin
            src_ptr_d = src;
            dst_ptr_d = dst;
            count_d   = len;
            err_d     = 1'b0;
            state_d   = (len != '0) ? S_READ : S_DONE;
          end else begin
            // Misaligned request: flag it and finish without touching the bus.
            err_d   = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_READ: begin
        bus_req = 1'b1;
        m_a     = src_ptr_q;
        if (bus_gnt) begin
          data_d  = m_rd;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        bus_req = 1'b1;
        m_a     = dst_ptr_q;
        m_wd    = data_q;
        m_we    = bus_gnt;
        if (bus_gnt) begin
          src_ptr_d = src_ptr_q + INC;
          dst_ptr_d = dst_ptr_q + INC;
          count_d   = count_q - LEN_W'(1);
          state_d   = (count_q == LEN_W'(1)) ? S_DONE : S_READ;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy = (state_q != S_IDLE);
  assign err  = err_q;

`ifdef DMA_CHECKSUM_EN
  logic [31:0] csum_q, csum_d;

  // Accumulate every word actually written; cleared when a new start is taken.
  always_comb begin
    csum_d = csum_q;
    if ((state_q == S_IDLE) && start) begin
      csum_d = '0;
    end else if ((state_q == S_WRITE) && bus_gnt) begin
      csum_d = csum_q + data_q;
    end
  end

  // Checksum register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end

  assign checksum = csum_q;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_dmem_dma_copier.sv
// Bench for dmem_dma_copier: word RAM plus switch/LED peripherals as the
// memory port, scoreboard of expected writes, table of copy vectors and
// hand-written reset / peripheral-streaming sequences.
module tb_dmem_dma_copier;
  localparam int LEN_W = 8;
  localparam logic [31:0] SW_ADDR  = 32'hC000_0000;
  localparam logic [31:0] LED_ADDR = 32'hC000_0004;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset, start, bus_gnt, mem_load;
  logic [31:0]      src, dst;
  logic [LEN_W-1:0] len;
  logic             bus_req, m_we, busy, done, err;
  logic [31:0]      m_a, m_wd, m_rd, checksum;

  logic             p_start, p_gnt;
  logic             p_bus_req, p_m_we, p_busy, p_done, p_err;
  logic [31:0]      p_m_a, p_m_wd, p_m_rd, p_checksum;

  logic [31:0] switches, leds, p_leds;
  int          p_led_writes, p_other_writes;
  logic [31:0] ram  [0:255];
  logic [31:0] gold [0:255];

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;
  wr_t exp_q[$];

  typedef struct {
    logic [31:0] src;
    logic [31:0] dst;
    int          len;
    int          drop_at;
    int          drop_len;
    int          exp_done;
    logic        exp_err;
  } vec_t;
  vec_t vecs[8];

  dmem_dma_copier #(.LEN_W(LEN_W), .ADDR_INC(4)) u_dut (
    .clk(clk), .reset(reset), .start(start), .src(src), .dst(dst), .len(len),
    .bus_req(bus_req), .bus_gnt(bus_gnt), .m_we(m_we), .m_a(m_a), .m_wd(m_wd),
    .m_rd(m_rd), .busy(busy), .done(done), .err(err), .checksum(checksum)
  );

  dmem_dma_copier #(.LEN_W(LEN_W), .ADDR_INC(0)) u_dut_fixed (
    .clk(clk), .reset(reset), .start(p_start), .src(src), .dst(dst), .len(len),
    .bus_req(p_bus_req), .bus_gnt(p_gnt), .m_we(p_m_we), .m_a(p_m_a), .m_wd(p_m_wd),
    .m_rd(p_m_rd), .busy(p_busy), .done(p_done), .err(p_err), .checksum(p_checksum)
  );

  function automatic logic [31:0] init_val(int i);
    return (i < 4) ? 32'(i + 1) : 32'h5A00_0000 + 32'(i * 17);
  endfunction

  assign m_rd   = (m_a == SW_ADDR) ? switches : ram[m_a[9:2]];
  assign p_m_rd = (p_m_a == SW_ADDR) ? switches : 32'hDEAD_0000;

  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 256; i++) ram[i] <= init_val(i);
      leds           <= '0;
      p_leds         <= '0;
      p_led_writes   <= 0;
      p_other_writes <= 0;
    end else begin
      if (m_we) begin
        if (m_a == LED_ADDR) leds <= m_wd;
        else ram[m_a[9:2]] <= m_wd;
      end
      if (p_m_we) begin
        if (p_m_a == LED_ADDR) begin
          p_leds       <= p_m_wd;
          p_led_writes <= p_led_writes + 1;
        end else begin
          p_other_writes <= p_other_writes + 1;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Called at every negedge during a transfer: bus hygiene + write scoreboard.
  task automatic mon();
    wr_t e;
    if (!bus_req) chk("bus_quiet_when_no_req", m_a | m_wd | {31'b0, m_we}, 32'h0);
    if (m_we) begin
      chk("we_only_with_gnt", {31'b0, bus_gnt}, 32'h1);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL wr_unexpected actual_a=%h actual_d=%h required=none", m_a, m_wd);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", m_a, e.a);
        chk("wr_data", m_wd, e.d);
      end
    end
  endtask

  task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input int n,
                          input int drop_at, input int drop_len,
                          output int done_cyc, output int busy_cnt,
                          output logic err_at_done, output logic [31:0] csum_at_done);
    int cyc;
    @(posedge clk); #1;
    src = s; dst = d; len = n[LEN_W-1:0]; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1; done_cyc = -1; busy_cnt = 0; err_at_done = 1'b0; csum_at_done = '0;
    while (cyc <= 300) begin
      bus_gnt = !((cyc >= drop_at) && (cyc < drop_at + drop_len));
      @(negedge clk);
      mon();
      if (busy) busy_cnt++;
      if (done) begin
        done_cyc     = cyc;
        err_at_done  = err;
        csum_at_done = checksum;
        break;
      end
      @(posedge clk); #1;
      cyc++;
    end
    bus_gnt = 1'b1;
    if (done_cyc < 0) begin
      total++;
      bad++;
      $display("FAIL done_timeout actual=none required=done within 300 cycles");
    end
    @(posedge clk); #1;
    @(negedge clk);
    chk("done_one_cycle_then_idle", {30'b0, done, busy}, 32'h0);
  endtask

  initial begin
    int          dc, bc, cyc;
    logic        ed;
    logic [31:0] cs, sum, sa, da, w;
    bit          al;

    reset = 1'b0; start = 1'b0; p_start = 1'b0; bus_gnt = 1'b1; p_gnt = 1'b1;
    mem_load = 1'b1; switches = '0; src = '0; dst = '0; len = '0;
    for (int i = 0; i < 256; i++) gold[i] = init_val(i);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ctrl", {27'b0, bus_req, m_we, busy, done, err}, 32'h0);
    chk("reset_bus", m_a | m_wd, 32'h0);
    chk("reset_checksum", checksum, 32'h0);
    chk("reset_fixed_inst", {26'b0, p_bus_req, p_m_we, p_busy, p_done, p_err, |p_checksum}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b1; mem_load = 1'b0;

    //            src            dst           len drop_at drop_len done err
    vecs[0] = '{32'h0000_0000, 32'h0000_0040, 4,  0, 0,  9, 1'b0};
    vecs[1] = '{32'h0000_0010, 32'h0000_0080, 0,  0, 0,  1, 1'b0};
    vecs[2] = '{32'h0000_0002, 32'h0000_0040, 3,  0, 0,  1, 1'b1};
    vecs[3] = '{32'h0000_0020, 32'h0000_0060, 2,  2, 3,  8, 1'b0};
    vecs[4] = '{32'h0000_0000, 32'h0000_00A0, 5,  0, 0, 11, 1'b0};
    vecs[5] = '{32'h0000_0000, 32'h0000_0041, 2,  0, 0,  1, 1'b1};
    vecs[6] = '{32'h0000_0100, 32'h0000_0200, 20, 5, 2, 43, 1'b0};
    vecs[7] = '{32'hFFFF_FFF8, 32'h0000_0300, 3,  0, 0,  7, 1'b0};

    for (int v = 0; v < 8; v++) begin
      al  = (vecs[v].src[1:0] == 2'b00) && (vecs[v].dst[1:0] == 2'b00);
      sum = '0;
      if (al) begin
        for (int i = 0; i < vecs[v].len; i++) begin
          sa = vecs[v].src + 32'(4 * i);
          da = vecs[v].dst + 32'(4 * i);
          w  = gold[sa[9:2]];
          exp_q.push_back('{da, w});
          gold[da[9:2]] = w;
          sum = sum + w;
        end
      end
      run_copy(vecs[v].src, vecs[v].dst, vecs[v].len, vecs[v].drop_at, vecs[v].drop_len,
               dc, bc, ed, cs);
      chk($sformatf("v%0d_done_cycle", v), 32'(dc), 32'(vecs[v].exp_done));
      chk($sformatf("v%0d_busy_cycles", v), 32'(bc), 32'(vecs[v].exp_done));
      chk($sformatf("v%0d_err_at_done", v), {31'b0, ed}, {31'b0, vecs[v].exp_err});
      chk($sformatf("v%0d_err_sticky", v), {31'b0, err}, {31'b0, vecs[v].exp_err});
      chk($sformatf("v%0d_writes_left", v), 32'(exp_q.size()), 32'h0);
      exp_q.delete();
      if (!vecs[v].exp_err) begin
`ifdef DMA_CHECKSUM_EN
        chk($sformatf("v%0d_checksum", v), cs, sum);
`else
        chk($sformatf("v%0d_checksum", v), cs, 32'h0);
`endif
      end
      for (int i = 0; i < vecs[v].len; i++) begin
        da = vecs[v].dst + 32'(4 * i);
        chk($sformatf("v%0d_ram_w%0d", v, i), ram[da[9:2]], gold[da[9:2]]);
      end
    end

    // Peripheral copy on the main instance: switches -> LEDs.
    switches = 32'h0000_02A5;
    exp_q.push_back('{LED_ADDR, 32'h0000_02A5});
    run_copy(SW_ADDR, LED_ADDR, 1, 0, 0, dc, bc, ed, cs);
    chk("periph_done_cycle", 32'(dc), 32'd3);
    chk("periph_leds", leds, 32'h0000_02A5);
    chk("periph_writes_left", 32'(exp_q.size()), 32'h0);
    exp_q.delete();

    // Fixed-address streaming (ADDR_INC=0): three reads of switches, three LED writes.
    @(posedge clk); #1;
    src = SW_ADDR; dst = LED_ADDR; len = 8'd3; p_start = 1'b1;
    @(posedge clk); #1;
    p_start = 1'b0;
    dc = -1;
    for (cyc = 1; cyc <= 50; cyc++) begin
      @(negedge clk);
      if (p_done) begin
        dc = cyc;
        break;
      end
      @(posedge clk); #1;
    end
    chk("stream_done_cycle", 32'(dc), 32'd7);
    chk("stream_leds", p_leds, 32'h0000_02A5);
    chk("stream_led_writes", 32'(p_led_writes), 32'd3);
    chk("stream_other_writes", 32'(p_other_writes), 32'd0);
    chk("stream_err_checksum", {31'b0, p_err} | p_checksum, 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("stream_idle_after", {30'b0, p_busy, p_bus_req}, 32'h0);

    // Reset during the second READ of a len=4 copy: only word 0 lands.
    w = gold[0];
    exp_q.push_back('{32'h0000_00C0, w});
    gold[48] = w;
    @(posedge clk); #1;
    src = 32'h0; dst = 32'h0000_00C0; len = 8'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      mon();
      @(posedge clk); #1;
    end
    chk("rst_mid_req_before", {31'b0, bus_req}, 32'h1);
    chk("rst_mid_addr_before", m_a, 32'h0000_0004);
    #2;
    reset = 1'b0;
    #1;
    chk("rst_mid_ctrl", {27'b0, bus_req, m_we, busy, done, err}, 32'h0);
    chk("rst_mid_bus", m_a | m_wd, 32'h0);
    chk("rst_mid_checksum", checksum, 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_stays_idle", {30'b0, busy, bus_req}, 32'h0);
    chk("rst_mid_word0", ram[48], gold[48]);
    chk("rst_mid_word1_untouched", ram[49], gold[49]);
    chk("rst_mid_writes_left", 32'(exp_q.size()), 32'h0);
    exp_q.delete();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
